lcd_pattern_gen: RTL and testbench
==================================

# lcd_pattern_gen

Pixel source stage feeding the RGB LCD timing driver. It takes the driver's pixel request coordinates and returns RGB565 `pixel_data` one `lcd_clk` later. It generates one of four test patterns, selected by a debounced push-button, with mode changes and animation updates applied only at frame boundaries so a frame never tears.

## Interface
- `H_DISP`, 11'd800, active pixels per line.
- `V_DISP`, 11'd480, active lines per frame.
- `DEBOUNCE_CNT`, 20'd660_000, stable-low cycles that qualify a key press (20 ms at 33 MHz).
- `BLOCK_SIZE`, 11'd64, edge length of the moving square in pixels.
- `BLOCK_STEP`, 11'd2, square displacement per frame on each axis.
- `AUTO_FRAMES`, 8'd120, frames per mode when auto-cycling is compiled in.
- `lcd_clk` input 1: pixel clock; all logic is on its rising edge.
- `sys_rst` input 1: asynchronous, active-high reset.
- `key_mode` input 1: raw mode key, active-low, asynchronous to `lcd_clk`.
- `pixel_xpos` input 11: request column, 1..H_DISP while requesting, 0 otherwise.
- `pixel_ypos` input 11: request row, 1..V_DISP while requesting, 0 otherwise.
- `pixel_data` output 16: RGB565 pixel, registered.
- `mode` output 2: active pattern (0 colorbar, 1 checker, 2 gradient, 3 moving block).

## Operation
- **Reset values:**
  - `pixel_data`=0, `mode`=0, `mode_pend`=0.
  - `frame_cnt`=0, `block_x`=`block_y`=0, `dir_x`=`dir_y`=+.
  - Key synchroniser flops=1, debounce counter=0, `pressed` flag=0.
- **Request valid:** `req` = (`pixel_xpos`≠0) and (`pixel_ypos`≠0). Local coordinates are x=`pixel_xpos`-1 and y=`pixel_ypos`-1, 11 bits each.
- **Output:** on each edge, `pixel_data` <= `req` ? pattern(x, y) : 16'h0000.
- **Mode 0, colorbar:** the screen is split into five bars of width H_DISP/5. Bar colours from x=0 are FFFF, 0000, F800, 07E0, 001F.
- **Mode 1, checker:** (x[5] xor y[5]) ? FFFF : 0000, giving 32×32 squares.
- **Mode 2, gradient:**
  - R = x[9:5], giving 0..24 across the line.
  - G = y[8:3], giving 0..59 down the frame.
  - B = `frame_cnt`[4:0].
- **Mode 3, moving block:** FFFF when x∈[`block_x`, `block_x`+BLOCK_SIZE) and y∈[`block_y`, `block_y`+BLOCK_SIZE); 001F otherwise.
- **Frame tick:** `frame_tick` = (`pixel_xpos`==H_DISP) && (`pixel_ypos`==V_DISP), i.e. the last request of the frame. On the tick edge:
  - `frame_cnt` increments; it is 8 bits and wraps 255→0.
  - `mode` <= `mode_pend`.
  - The square moves.
  - The pixel registered on this same edge uses the pre-update values of all of these.
- **Square motion, x axis:**
  - `dir_x`=+: if `block_x`+BLOCK_STEP ≥ H_DISP-BLOCK_SIZE, then `block_x`=H_DISP-BLOCK_SIZE and `dir_x`=−; else `block_x`+=BLOCK_STEP.
  - `dir_x`=−: if `block_x` ≤ BLOCK_STEP, then `block_x`=0 and `dir_x`=+; else `block_x`-=BLOCK_STEP.
  - The y axis uses the same rules with V_DISP.
  - The square moves in every mode, not only mode 3.
- **Key path:**
  - Two-flop synchroniser feeds the debouncer.
  - While the synchronised key is low and `pressed`=0, the counter counts. At DEBOUNCE_CNT-1 the counter saturates, `pressed` is set, and `mode_pend` increments once (3→0 wraps).
  - Synchronised key high clears the counter and `pressed`. One press gives exactly one increment, however long it is held.
- **Simultaneous events:** a press qualifying on the `frame_tick` edge updates `mode_pend` only. It reaches `mode` at the next tick.
- **Mid-operation reset:** all state returns to its reset values immediately. The next frame renders mode 0.

## Timing
- Latency from `pixel_xpos`/`pixel_ypos` to `pixel_data` is exactly 1 cycle, with no bubbles and no back-pressure.
- Pattern logic must close timing within one `lcd_clk` period. The constant bar boundaries are computed from parameters.
- Key press to `mode_pend` update: 2 synchroniser cycles + DEBOUNCE_CNT cycles.
- `mode_pend` to `mode`: the next `frame_tick`.

## Configuration
- **`PATTERN_AUTO_CYCLE_EN` defined:**
  - An 8-bit auto counter increments on each `frame_tick`.
  - When it reaches AUTO_FRAMES-1 on a tick, it clears and `mode_pend` increments, wrapping 3→0.
  - A qualified key press clears the auto counter.
  - If a key press and the auto advance fall on the same edge, the key wins and `mode_pend` increments once.
- **Macro undefined:** no auto counter exists; `mode` changes only via `key_mode`.

## Test plan
- **Reset and idle:** assert `sys_rst` with xpos=5, ypos=5 → `pixel_data`=0 and `mode`=0 during reset. After release, the next edge gives FFFF (colorbar bar 0).
- **Colorbar boundaries, mode 0:** xpos=160 → FFFF; xpos=161 → 0000; xpos=641 → 001F; xpos=0 → 0000. Each value appears exactly one cycle after its request.
- **Mode switching (DEBOUNCE_CNT=4):**
  - A 3-cycle low glitch → no change.
  - A 10-cycle low pulse → `mode_pend`=1, `mode` still 0 until the tick (xpos=800, ypos=480), then `mode`=1.
  - Holding the key low for 1000 cycles → exactly one increment.
- **Checker and gradient:**
  - Mode 1: (xpos, ypos)=(33, 1) → FFFF; (33, 33) → 0000.
  - Mode 2 after 3 ticks: (xpos, ypos)=(801-1, 1) → R=24, G=0, B=3, i.e. C003.
- **Block bounce, mode 3:** run 400 ticks. `block_x` steps 0, 2, …, 736, then 734. `block_y` reaches 416, then reverses. Pixel (`block_x`+1, `block_y`+1) → FFFF; (`block_x`+65, `block_y`+1) → 001F.
- **Auto cycle (`PATTERN_AUTO_CYCLE_EN`, AUTO_FRAMES=3):** 3 ticks → `mode`=1 on the 4th tick. A key press on the same edge as the auto advance gives a single increment.

Source files
------------

// File: rtl/lcd_pattern_gen.sv
// RGB565 test-pattern source for the LCD timing driver: four selectable patterns, tear-free updates.
// Optional build macro PATTERN_AUTO_CYCLE_EN adds timed automatic mode cycling.
module lcd_pattern_gen #(
    parameter logic [10:0] H_DISP       = 11'd800,
    parameter logic [10:0] V_DISP       = 11'd480,
    parameter logic [19:0] DEBOUNCE_CNT = 20'd660_000,
    parameter logic [10:0] BLOCK_SIZE   = 11'd64,
    parameter logic [10:0] BLOCK_STEP   = 11'd2,
    parameter logic [7:0]  AUTO_FRAMES  = 8'd120
) (
    input  logic        lcd_clk,
    input  logic        sys_rst,
    input  logic        key_mode,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    output logic [15:0] pixel_data,
    output logic [1:0]  mode
);

    localparam logic [10:0] BAR_W = H_DISP / 11'd5;
    localparam logic [10:0] BAR_2 = BAR_W * 11'd2;
    localparam logic [10:0] BAR_3 = BAR_W * 11'd3;
    localparam logic [10:0] BAR_4 = BAR_W * 11'd4;
    localparam logic [10:0] X_MAX = H_DISP - BLOCK_SIZE;
    localparam logic [10:0] Y_MAX = V_DISP - BLOCK_SIZE;

    logic [15:0] r_pixel;
    logic [1:0]  r_mode;
    logic [1:0]  r_mode_pend;
    logic [7:0]  r_frame_cnt;
    logic [10:0] r_block_x;
    logic [10:0] r_block_y;
    logic        r_dir_x;
    logic        r_dir_y;
    logic        r_key_s1;
    logic        r_key_s2;
    logic [19:0] r_db_cnt;
    logic        r_pressed;

    logic        w_req;
    logic        w_tick;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_in_x;
    logic        w_in_y;
    logic [15:0] w_pattern;
    logic        w_key_fire;
    logic        w_auto_fire;
    logic        w_unused;

    // Bounce one axis: returns {dir, pos}; dir 0 moves up the axis, 1 moves down.
    function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic dir,
                                              input logic [10:0] lim);
        if (!dir) begin
            if ({1'b0, pos} + {1'b0, BLOCK_STEP} >= {1'b0, lim})
                return {1'b1, lim};
            return {1'b0, pos + BLOCK_STEP};
        end
        if (pos <= BLOCK_STEP)
            return {1'b0, 11'd0};
        return {1'b1, pos - BLOCK_STEP};
    endfunction

    assign w_req    = (pixel_xpos != 11'd0) && (pixel_ypos != 11'd0);
    assign w_tick   = (pixel_xpos == H_DISP) && (pixel_ypos == V_DISP);
    assign w_x      = pixel_xpos - 11'd1;
    assign w_y      = pixel_ypos - 11'd1;
    assign w_in_x   = (w_x >= r_block_x) && ({1'b0, w_x} < {1'b0, r_block_x} + {1'b0, BLOCK_SIZE});
    assign w_in_y   = (w_y >= r_block_y) && ({1'b0, w_y} < {1'b0, r_block_y} + {1'b0, BLOCK_SIZE});
    assign w_unused = ^r_frame_cnt[7:5];

    always_comb begin
        w_pattern = 16'h0000;
        case (r_mode)
            2'd0: begin
                if (w_x < BAR_W)      w_pattern = 16'hFFFF;
                else if (w_x < BAR_2) w_pattern = 16'h0000;
                else if (w_x < BAR_3) w_pattern = 16'hF800;
                else if (w_x < BAR_4) w_pattern = 16'h07E0;
                else                  w_pattern = 16'h001F;
            end
            2'd1:    w_pattern = (w_x[5] ^ w_y[5]) ? 16'hFFFF : 16'h0000;
            2'd2:    w_pattern = {w_x[9:5], w_y[8:3], r_frame_cnt[4:0]};
            default: w_pattern = (w_in_x && w_in_y) ? 16'hFFFF : 16'h001F;
        endcase
    end

    // Everything frame-scoped changes only on the tick edge; that edge's pixel still sees old state.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pixel     <= 16'h0000;
            r_mode      <= 2'd0;
            r_frame_cnt <= 8'd0;
            r_block_x   <= 11'd0;
            r_block_y   <= 11'd0;
            r_dir_x     <= 1'b0;
            r_dir_y     <= 1'b0;
        end else begin
            r_pixel <= w_req ? w_pattern : 16'h0000;
            if (w_tick) begin
                r_frame_cnt          <= r_frame_cnt + 8'd1;
                r_mode               <= r_mode_pend;
                {r_dir_x, r_block_x} <= step_axis(r_block_x, r_dir_x, X_MAX);
                {r_dir_y, r_block_y} <= step_axis(r_block_y, r_dir_y, Y_MAX);
            end
        end
    end

    assign w_key_fire = !r_key_s2 && !r_pressed && (r_db_cnt == DEBOUNCE_CNT - 20'd1);

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_key_s1    <= 1'b1;
            r_key_s2    <= 1'b1;
            r_db_cnt    <= 20'd0;
            r_pressed   <= 1'b0;
            r_mode_pend <= 2'd0;
        end else begin
            r_key_s1 <= key_mode;
            r_key_s2 <= r_key_s1;
            if (r_key_s2) begin
                r_db_cnt  <= 20'd0;
                r_pressed <= 1'b0;
            end else if (w_key_fire) begin
                r_pressed <= 1'b1;
            end else if (!r_pressed) begin
                r_db_cnt <= r_db_cnt + 20'd1;
            end
            if (w_key_fire || w_auto_fire)
                r_mode_pend <= r_mode_pend + 2'd1;
        end
    end

`ifdef PATTERN_AUTO_CYCLE_EN
    logic [7:0] r_auto_cnt;

    assign w_auto_fire = w_tick && (r_auto_cnt == AUTO_FRAMES - 8'd1);

    // A key press restarts the dwell period and takes precedence over a coincident auto advance.
    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst)
            r_auto_cnt <= 8'd0;
        else if (w_key_fire)
            r_auto_cnt <= 8'd0;
        else if (w_tick)
            r_auto_cnt <= w_auto_fire ? 8'd0 : r_auto_cnt + 8'd1;
    end
`else
    logic w_unused_auto;

    assign w_auto_fire   = 1'b0;
    assign w_unused_auto = ^AUTO_FRAMES;
`endif

    assign pixel_data = r_pixel;
    assign mode       = r_mode;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen: reset, colorbar edges, key debounce, checker, gradient, block bounce.
module tb_lcd_pattern_gen;

    logic        lcd_clk    = 1'b0;
    logic        sys_rst    = 1'b1;
    logic        key_mode   = 1'b1;
    logic [10:0] pixel_xpos = 11'd0;
    logic [10:0] pixel_ypos = 11'd0;
    logic [15:0] pixel_data;
    logic [1:0]  mode;

    int n_vec  = 0;
    int n_err  = 0;
    int n_tick = 0;

    lcd_pattern_gen #(
        .H_DISP      (11'd800),
        .V_DISP      (11'd480),
        .DEBOUNCE_CNT(20'd4),
        .BLOCK_SIZE  (11'd64),
        .BLOCK_STEP  (11'd2),
        .AUTO_FRAMES (8'd3)
    ) dut (
        .lcd_clk   (lcd_clk),
        .sys_rst   (sys_rst),
        .key_mode  (key_mode),
        .pixel_xpos(pixel_xpos),
        .pixel_ypos(pixel_ypos),
        .pixel_data(pixel_data),
        .mode      (mode)
    );

    always #5 lcd_clk = ~lcd_clk;

    // Present one request, then sample 1 ns after the edge that registers it.
    task automatic drive(input logic [10:0] x, input logic [10:0] y);
        pixel_xpos = x;
        pixel_ypos = y;
        @(posedge lcd_clk);
        #1;
        if (x == 11'd800 && y == 11'd480 && !sys_rst)
            n_tick++;
    endtask

    task automatic do_tick();
        drive(11'd800, 11'd480);
    endtask

    task automatic press(input int n_low);
        key_mode = 1'b0;
        repeat (n_low) drive(11'd0, 11'd0);
        key_mode = 1'b1;
        repeat (8) drive(11'd0, 11'd0);
    endtask

    // Triangle-wave closed form for the square position after n ticks.
    function automatic int tri_pos(input int n, input int span);
        int p;
        p = (2 * n) % (2 * span);
        return (p <= span) ? p : (2 * span - p);
    endfunction

    task automatic test_reset();
        sys_rst    = 1'b1;
        pixel_xpos = 11'd5;
        pixel_ypos = 11'd5;
        #1;
        n_vec++;
        if (pixel_data !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_pix: got %h expected %h", pixel_data, 16'h0000);
        end
        n_vec++;
        if (mode !== 2'd0) begin
            n_err++;
            $display("FAIL rst_mode: got %0d expected %0d", mode, 0);
        end
        @(posedge lcd_clk);
        #1;
        n_vec++;
        if (pixel_data !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_pix_edge: got %h expected %h", pixel_data, 16'h0000);
        end
        sys_rst = 1'b0;
        n_tick  = 0;
        drive(11'd5, 11'd5);
        n_vec++;
        if (pixel_data !== 16'hFFFF) begin
            n_err++;
            $display("FAIL rst_release: got %h expected %h", pixel_data, 16'hFFFF);
        end
    endtask

    task automatic test_colorbar();
        logic [10:0] xs [13] = '{11'd160, 11'd161, 11'd320, 11'd321, 11'd480, 11'd481, 11'd640,
                                 11'd641, 11'd0,   11'd800, 11'd1,   11'd5,   11'd300};
        logic [10:0] ys [13] = '{11'd1, 11'd1, 11'd1, 11'd1, 11'd1, 11'd1, 11'd1,
                                 11'd1, 11'd1, 11'd1, 11'd1, 11'd0, 11'd200};
        logic [15:0] ex [13] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hF800, 16'hF800, 16'h07E0, 16'h07E0,
                                 16'h001F, 16'h0000, 16'h001F, 16'hFFFF, 16'h0000, 16'h0000};
        for (int i = 0; i < 13; i++) begin
            drive(xs[i], ys[i]);
            n_vec++;
            if (pixel_data !== ex[i]) begin
                n_err++;
                $display("FAIL colorbar[%0d] x=%0d y=%0d: got %h expected %h",
                         i, xs[i], ys[i], pixel_data, ex[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        press(3);
        do_tick();
        n_vec++;
        if (mode !== 2'd0) begin
            n_err++;
            $display("FAIL glitch_mode: got %0d expected %0d", mode, 0);
        end
        press(10);
        n_vec++;
        if (mode !== 2'd0) begin
            n_err++;
            $display("FAIL pend_before_tick: got %0d expected %0d", mode, 0);
        end
        drive(11'd1, 11'd1);
        n_vec++;
        if (pixel_data !== 16'hFFFF) begin
            n_err++;
            $display("FAIL pend_still_colorbar: got %h expected %h", pixel_data, 16'hFFFF);
        end
        do_tick();
        n_vec++;
        if (pixel_data !== 16'h001F) begin
            n_err++;
            $display("FAIL tick_pixel_old_mode: got %h expected %h", pixel_data, 16'h001F);
        end
        n_vec++;
        if (mode !== 2'd1) begin
            n_err++;
            $display("FAIL mode_after_tick: got %0d expected %0d", mode, 1);
        end
    endtask

    task automatic test_checker();
        logic [10:0] xs [5] = '{11'd33, 11'd33, 11'd1, 11'd1, 11'd32};
        logic [10:0] ys [5] = '{11'd1, 11'd33, 11'd1, 11'd33, 11'd1};
        logic [15:0] ex [5] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            drive(xs[i], ys[i]);
            n_vec++;
            if (pixel_data !== ex[i]) begin
                n_err++;
                $display("FAIL checker[%0d] x=%0d y=%0d: got %h expected %h",
                         i, xs[i], ys[i], pixel_data, ex[i]);
            end
        end
    endtask

    task automatic test_hold_and_gradient();
        logic [10:0] xs [3] = '{11'd800, 11'd1, 11'd33};
        logic [10:0] ys [3] = '{11'd1, 11'd480, 11'd9};
        logic [15:0] ex [3] = '{16'hC003, 16'h0763, 16'h0823};
        press(1000);
        do_tick();
        n_vec++;
        if (mode !== 2'd2) begin
            n_err++;
            $display("FAIL hold_mode: got %0d expected %0d", mode, 2);
        end
        // Three ticks since reset, so blue carries 3.
        for (int i = 0; i < 3; i++) begin
            drive(xs[i], ys[i]);
            n_vec++;
            if (pixel_data !== ex[i]) begin
                n_err++;
                $display("FAIL gradient[%0d] x=%0d y=%0d: got %h expected %h",
                         i, xs[i], ys[i], pixel_data, ex[i]);
            end
        end
        do_tick();
        n_vec++;
        if (mode !== 2'd2) begin
            n_err++;
            $display("FAIL hold_single_inc: got %0d expected %0d", mode, 2);
        end
        drive(11'd800, 11'd1);
        n_vec++;
        if (pixel_data !== 16'hC004) begin
            n_err++;
            $display("FAIL gradient_frame_cnt: got %h expected %h", pixel_data, 16'hC004);
        end
    endtask

    task automatic test_block_bounce();
        int bx;
        int by;
        press(10);
        do_tick();
        n_vec++;
        if (mode !== 2'd3) begin
            n_err++;
            $display("FAIL block_mode: got %0d expected %0d", mode, 3);
        end
        for (int k = 0; k < 400; k++) begin
            bx = tri_pos(n_tick, 736);
            by = tri_pos(n_tick, 416);
            drive(11'(bx + 1), 11'(by + 1));
            n_vec++;
            if (pixel_data !== 16'hFFFF) begin
                n_err++;
                $display("FAIL block_in tick=%0d bx=%0d by=%0d: got %h expected %h",
                         n_tick, bx, by, pixel_data, 16'hFFFF);
            end
            drive(11'(bx + 64), 11'(by + 64));
            n_vec++;
            if (pixel_data !== 16'hFFFF) begin
                n_err++;
                $display("FAIL block_corner tick=%0d bx=%0d by=%0d: got %h expected %h",
                         n_tick, bx, by, pixel_data, 16'hFFFF);
            end
            drive(11'(bx + 65), 11'(by + 1));
            n_vec++;
            if (pixel_data !== 16'h001F) begin
                n_err++;
                $display("FAIL block_right tick=%0d bx=%0d by=%0d: got %h expected %h",
                         n_tick, bx, by, pixel_data, 16'h001F);
            end
            drive(11'(bx + 1), 11'(by + 65));
            n_vec++;
            if (pixel_data !== 16'h001F) begin
                n_err++;
                $display("FAIL block_below tick=%0d bx=%0d by=%0d: got %h expected %h",
                         n_tick, bx, by, pixel_data, 16'h001F);
            end
            if (bx > 0) begin
                drive(11'(bx), 11'(by + 1));
                n_vec++;
                if (pixel_data !== 16'h001F) begin
                    n_err++;
                    $display("FAIL block_left tick=%0d bx=%0d by=%0d: got %h expected %h",
                             n_tick, bx, by, pixel_data, 16'h001F);
                end
            end
            do_tick();
        end
    endtask

    task automatic test_midreset();
        pixel_xpos = 11'd1;
        pixel_ypos = 11'd1;
        sys_rst    = 1'b1;
        #1;
        n_vec++;
        if (pixel_data !== 16'h0000 || mode !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_async: got %h/%0d expected %h/%0d", pixel_data, mode, 16'h0000, 0);
        end
        @(posedge lcd_clk);
        #1;
        sys_rst = 1'b0;
        n_tick  = 0;
        drive(11'd1, 11'd1);
        n_vec++;
        if (pixel_data !== 16'hFFFF) begin
            n_err++;
            $display("FAIL midrst_colorbar: got %h expected %h", pixel_data, 16'hFFFF);
        end
        do_tick();
        n_vec++;
        if (mode !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_pend_cleared: got %0d expected %0d", mode, 0);
        end
    endtask

`ifdef PATTERN_AUTO_CYCLE_EN
    task automatic test_auto_cycle();
        logic [1:0] ex [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                // Key qualifies on the 6th edge after going low, coinciding with the auto advance.
                key_mode = 1'b0;
                repeat (5) drive(11'd0, 11'd0);
                do_tick();
                key_mode = 1'b1;
                repeat (6) drive(11'd0, 11'd0);
            end else begin
                do_tick();
            end
            n_vec++;
            if (mode !== ex[i]) begin
                n_err++;
                $display("FAIL auto_mode tick=%0d: got %0d expected %0d", i + 1, mode, ex[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PATTERN_AUTO_CYCLE_EN
        test_auto_cycle();
`else
        test_colorbar();
        test_mode_switch();
        test_checker();
        test_hold_and_gradient();
        test_block_bounce();
        test_midreset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
